// File: rtl/mc_data_capture_if.sv
// rtl/mc_data_capture_if.sv - captured-word stream between mc_data_capture and its consumer
interface mc_data_capture_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mc_data_capture.sv
// rtl/mc_data_capture.sv - phase-tracked capture of a divided-clock word into a 2-entry stream buffer
// Optional hold-window check of data_in: MC_CAPTURE_STABILITY_CHECK_EN
module mc_data_capture #(
  parameter int WIDTH         = 32,
  parameter int RATIO         = 2,
  parameter int CAPTURE_PHASE = 1
) (
  input  logic               pll_clock,
  input  logic               reset_n,
  input  logic               align,
  input  logic               capture_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               clear,
  output logic               overflow,
  output logic               unstable,
  mc_data_capture_if.master  out_if
);
  localparam int            PW         = $clog2(RATIO);
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);
  localparam logic [PW-1:0] CAP_PHASE  = PW'(CAPTURE_PHASE);

  logic [PW-1:0]    phase;
  logic             capture;
  logic             pop;
  logic             drop;
  logic             push_ok;
  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [WIDTH-1:0] last_data;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (align || phase == LAST_PHASE) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign capture = capture_en && (phase == CAP_PHASE);
  assign pop     = out_if.out_valid && out_if.out_ready;
  // A full buffer still accepts the word when the head leaves on the same edge.
  assign drop    = capture && (count == 2'd2) && !pop;
  assign push_ok = capture && !drop;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      last_data <= '0;
    end else begin
      if (push_ok) begin
        mem[tail] <= data_in;
        tail      <= ~tail;
      end
      if (pop) begin
        last_data <= mem[head];
        head      <= ~head;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_if.out_valid = (count != 2'd0);
  assign out_if.out_data  = out_if.out_valid ? mem[head] : last_data;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef MC_CAPTURE_STABILITY_CHECK_EN
  localparam logic [PW-1:0] SHADOW_PHASE = PW'((CAPTURE_PHASE + RATIO - 1) % RATIO);

  logic [WIDTH-1:0] shadow;
  logic             unstable_set;

  // Shadow holds the word one phase before capture; any change by the capture edge is a hold violation.
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (phase == SHADOW_PHASE) begin
      shadow <= data_in;
    end
  end

  assign unstable_set = capture && (data_in != shadow);

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      unstable <= 1'b0;
    end else if (unstable_set) begin
      unstable <= 1'b1;
    end else if (clear) begin
      unstable <= 1'b0;
    end
  end
`else
  assign unstable = 1'b0;
`endif

endmodule
